// File: rtl/sparse_bind_encoder.sv
// Sparse HDC bind encoder: turns one (level, feature id) pair into a
// stream of per-segment active indices, generated arithmetically.
module sparse_bind_encoder #(
   parameter int NUM_SEG    = 16,
   parameter int SEG_W      = 6,
   parameter int LEVELS     = 10,
   parameter int LEVEL_W    = 4,
   parameter int ID_W       = 10,
   parameter int SEG_STRIDE = 13,
   parameter int LEVEL_STEP = 3
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LEVEL_W-1:0]         level,
   input  logic [ID_W-1:0]            feature_id,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(NUM_SEG)-1:0] out_seg,
   output logic [SEG_W-1:0]           out_idx,
   output logic                       out_last,
   output logic                       lvl_err
);

   localparam int SW = $clog2(NUM_SEG);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SW-1:0]     seg;
   logic [SEG_W-1:0]  cur;
   logic [SEG_W-1:0]  step;
   logic [LEVEL_W-1:0] lvl;
   logic              over;
   logic              accept;
   logic              fire;
   logic              last;

   // Out-of-range levels clamp to the top level
   always_comb begin
      over = 32'(level) >= LEVELS;
      lvl  = over ? LEVEL_W'(LEVELS - 1) : level;
   end

   always_comb begin
      last   = (state == EMIT) && (seg == SW'(NUM_SEG - 1));
      accept = in_valid && in_ready;
      fire   = out_valid && out_ready;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready && last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         seg  <= '0;
         cur  <= '0;
         step <= '0;
      end else if (accept) begin
         cur  <= SEG_W'(32'(lvl) * LEVEL_STEP + 32'(feature_id));
         step <= SEG_W'(SEG_STRIDE + 2 * 32'(feature_id));
         seg  <= '0;
      end else if (fire) begin
         cur  <= cur + step;
         seg  <= seg + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)             lvl_err <= 1'b0;
      else if (accept && over) lvl_err <= 1'b1;
   end

   assign out_seg  = seg;
   assign out_idx  = cur;
   assign out_last = last;

endmodule

// File: tb/tb_sparse_bind_encoder.sv
// Scoreboard bench for sparse_bind_encoder: expected beats are queued
// at accept time and compared as the DUT hands them off.
module tb_sparse_bind_encoder;

   localparam int NUM_SEG    = 16;
   localparam int SEG_W      = 6;
   localparam int LEVELS     = 10;
   localparam int LEVEL_W    = 4;
   localparam int ID_W       = 10;
   localparam int SEG_STRIDE = 13;
   localparam int LEVEL_STEP = 3;

   logic               clk = 1'b0;
   logic               nrst = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [LEVEL_W-1:0] level = '0;
   logic [ID_W-1:0]    feature_id = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [3:0]         out_seg;
   logic [SEG_W-1:0]   out_idx;
   logic               out_last;
   logic               lvl_err;

   sparse_bind_encoder #(
      .NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .LEVELS(LEVELS),
      .LEVEL_W(LEVEL_W), .ID_W(ID_W), .SEG_STRIDE(SEG_STRIDE),
      .LEVEL_STEP(LEVEL_STEP)
   ) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready),
      .level(level), .feature_id(feature_id),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_seg(out_seg), .out_idx(out_idx),
      .out_last(out_last), .lvl_err(lvl_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       seg;
      logic [SEG_W-1:0] idx;
      logic             last;
   } beat_t;

   beat_t sb[$];
   int    total = 0;
   int    bad = 0;
   int    beats = 0;
   int    rdy_mode = 0;
   logic  held_v = 1'b0;
   beat_t held;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // 0: always ready, 1: ready pattern 1,0,0,1,0,0,...
   initial begin
      int rc;
      rc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) begin
            out_ready = 1'b1;
         end else begin
            out_ready = (rc % 3 == 0);
            rc++;
         end
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (!nrst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_seg", 32'(out_seg), 32'(held.seg));
            check("stall_idx", 32'(out_idx), 32'(held.idx));
            check("stall_last", 32'(out_last), 32'(held.last));
         end
         held_v = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_beat", 32'(sb.size()), 1);
               end else begin
                  e = sb.pop_front();
                  check("seg", 32'(out_seg), 32'(e.seg));
                  check("idx", 32'(out_idx), 32'(e.idx));
                  check("last", 32'(out_last), 32'(e.last));
                  beats++;
               end
            end else begin
               held_v = 1'b1;
               held = '{seg: out_seg, idx: out_idx, last: out_last};
            end
         end
      end
   end

   task automatic send(input int lv, input int id, input bit timing);
      int    n;
      int    lvl;
      beat_t b;
      lvl = (lv >= LEVELS) ? LEVELS - 1 : lv;
      beats = 0;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 32'(in_ready), 1);
      for (int s = 0; s < NUM_SEG; s++) begin
         b.seg  = 4'(s);
         b.idx  = SEG_W'((lvl * LEVEL_STEP + id
                  + s * (SEG_STRIDE + 2 * id)) % 64);
         b.last = (s == NUM_SEG - 1);
         sb.push_back(b);
      end
      in_valid   = 1'b1;
      level      = LEVEL_W'(lv);
      feature_id = ID_W'(id);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (timing) begin
         @(negedge clk);
         check("first_valid", 32'(out_valid), 1);
         check("busy_ready", 32'(in_ready), 0);
         n = 1;
         while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("ready_latency", 32'(n), 17);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(sb.size()), 0);
      check("beats", 32'(beats), NUM_SEG);
   endtask

   initial begin
      int n;
      #12;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_seg", 32'(out_seg), 0);
      check("rst_out_idx", 32'(out_idx), 0);
      check("rst_lvl_err", 32'(lvl_err), 0);
      @(negedge clk);
      nrst = 1'b1;

      send(0, 0, 1);
      drain();
      send(2, 1, 0);
      drain();
      check("lvl_err_ok", 32'(lvl_err), 0);
      send(12, 0, 0);
      drain();
      check("lvl_err_set", 32'(lvl_err), 1);
      send(0, 1023, 0);
      drain();
      check("lvl_err_sticky", 32'(lvl_err), 1);

      rdy_mode = 1;
      send(5, 77, 0);
      drain();
      rdy_mode = 0;

      // Reset mid-emission at segment 5
      send(3, 9, 0);
      n = 0;
      while (!(out_valid && out_seg == 4'd5) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reach_seg5", 32'(out_seg), 5);
      #2;
      nrst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_lvl_err", 32'(lvl_err), 0);
      check("mid_rst_ready", 32'(in_ready), 1);
      check("mid_rst_seg", 32'(out_seg), 0);
      check("mid_rst_idx", 32'(out_idx), 0);
      check("mid_rst_last", 32'(out_last), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready), 1);
      check("post_rst_valid", 32'(out_valid), 0);
      send(1, 2, 1);
      drain();
      check("final_lvl_err", 32'(lvl_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
